// File: rtl/mbist_comparator_if.sv
// mbist_comparator_if
//   Bundles the compare-request bus from the MBIST data generator with the
//   result/fail-log bus read by the MBIST controller.
//   master : generator/controller side (drives read data, expected data,
//            mask, address, march element and log pop; observes results)
//   slave  : comparator side
// Parameters:
//   ADDR_W : SRAM address width
//   CNT_W  : fail counter width
interface mbist_comparator_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              RD_VALID;
    logic [7:0]        RD_DATA;
    logic [7:0]        EXP_DATA;
    logic [7:0]        CMP_MASK;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [3:0]        gen_Turn;
    logic              LOG_POP;

    logic              FAIL_PULSE;
    logic              FAIL;
    logic [CNT_W-1:0]  FAIL_CNT;
    logic              FIRST_VALID;
    logic [ADDR_W-1:0] FIRST_ADDR;
    logic [7:0]        FIRST_XOR;
    logic [3:0]        FIRST_TURN;
    logic              LOG_VALID;
    logic [ADDR_W-1:0] LOG_ADDR;
    logic [7:0]        LOG_XOR;
    logic              LOG_FULL;
    logic              LOG_OVF;

    modport master (
        output RD_VALID, RD_DATA, EXP_DATA, CMP_MASK, RD_ADDR, gen_Turn, LOG_POP,
        input  FAIL_PULSE, FAIL, FAIL_CNT, FIRST_VALID, FIRST_ADDR, FIRST_XOR,
               FIRST_TURN, LOG_VALID, LOG_ADDR, LOG_XOR, LOG_FULL, LOG_OVF
    );

    modport slave (
        input  RD_VALID, RD_DATA, EXP_DATA, CMP_MASK, RD_ADDR, gen_Turn, LOG_POP,
        output FAIL_PULSE, FAIL, FAIL_CNT, FIRST_VALID, FIRST_ADDR, FIRST_XOR,
               FIRST_TURN, LOG_VALID, LOG_ADDR, LOG_XOR, LOG_FULL, LOG_OVF
    );
endinterface

// File: rtl/mbist_comparator.sv
// mbist_comparator
//   MBIST response analyser. Compares SRAM read data with the generator's
//   expected byte under a per-bit ignore mask, keeps a sticky fail flag and a
//   saturating fail counter, captures the first failure and queues failure
//   records in a small first-word-fall-through log.
// Ports:
//   CLK     : clock, all logic on rising edge
//   RESET   : synchronous active-high reset
//   CMP_CLR : synchronous clear of all results (same effect as RESET)
//   bus     : compare request / result / fail-log bus (slave side)
// Pipeline: stage 1 registers the masked syndrome, stage 2 updates results,
//   so a failing read at edge N is visible after edge N+1.
module mbist_comparator #(
    parameter int ADDR_W    = 8,
    parameter int CNT_W     = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CMP_CLR,
    mbist_comparator_if.slave  bus
);
    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int LCW   = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 8;
    localparam logic [LCW-1:0] DEPTH_C = LCW'(LOG_DEPTH);

    logic clr;
    assign clr = RESET | CMP_CLR;

    // stage 1
    logic              s1_valid;
    logic [7:0]        s1_syn;
    logic [ADDR_W-1:0] s1_addr;
    logic [3:0]        s1_turn;
    logic              s1_fail;

    // stage 2 / results
    logic              fail_pulse;
    logic              fail_flag;
    logic [CNT_W-1:0]  fail_cnt;
    logic              first_valid;
    logic [ADDR_W-1:0] first_addr;
    logic [7:0]        first_xor;
    logic [3:0]        first_turn;
    logic              log_ovf;

    // fail log
    logic [ENT_W-1:0]  log_mem [LOG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LCW-1:0]    log_cnt;
    logic              log_valid;
    logic              log_full;
    logic              log_pop;
    logic              push_ok;
    logic [ENT_W-1:0]  log_head;

    assign s1_fail   = s1_valid & (|s1_syn);
    assign log_valid = (log_cnt != '0);
    assign log_full  = (log_cnt == DEPTH_C);
    assign log_pop   = bus.LOG_POP & log_valid;
    // A full log still accepts a push when the head leaves at the same edge.
    assign push_ok   = s1_fail & (~log_full | log_pop);
    assign log_head  = log_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (clr) begin
            s1_valid <= 1'b0;
            s1_syn   <= '0;
            s1_addr  <= '0;
            s1_turn  <= '0;
        end else begin
            s1_valid <= bus.RD_VALID;
            if (bus.RD_VALID) begin
                s1_syn  <= (bus.RD_DATA ^ bus.EXP_DATA) & ~bus.CMP_MASK;
                s1_addr <= bus.RD_ADDR;
                s1_turn <= bus.gen_Turn;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            fail_pulse  <= 1'b0;
            fail_flag   <= 1'b0;
            fail_cnt    <= '0;
            first_valid <= 1'b0;
            first_addr  <= '0;
            first_xor   <= '0;
            first_turn  <= '0;
            log_ovf     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            log_cnt     <= '0;
        end else begin
            fail_pulse <= s1_fail;
            if (s1_fail) begin
                fail_flag <= 1'b1;
                if (fail_cnt != '1)
                    fail_cnt <= fail_cnt + 1'b1;
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_addr  <= s1_addr;
                    first_xor   <= s1_syn;
                    first_turn  <= s1_turn;
                end
                if (!push_ok)
                    log_ovf <= 1'b1;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (log_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, log_pop})
                2'b10:   log_cnt <= log_cnt + 1'b1;
                2'b01:   log_cnt <= log_cnt - 1'b1;
                default: log_cnt <= log_cnt;
            endcase
        end
    end

    // Storage is not reset; entries are only visible through log_cnt.
    always_ff @(posedge CLK) begin
        if (push_ok && !clr)
            log_mem[wr_ptr] <= {s1_addr, s1_syn};
    end

    assign bus.FAIL_PULSE  = fail_pulse;
    assign bus.FAIL        = fail_flag;
    assign bus.FAIL_CNT    = fail_cnt;
    assign bus.FIRST_VALID = first_valid;
    assign bus.FIRST_ADDR  = first_addr;
    assign bus.FIRST_XOR   = first_xor;
    assign bus.FIRST_TURN  = first_turn;
    assign bus.LOG_VALID   = log_valid;
    assign bus.LOG_ADDR    = log_valid ? log_head[ENT_W-1:8] : '0;
    assign bus.LOG_XOR     = log_valid ? log_head[7:0] : '0;
    assign bus.LOG_FULL    = log_full;
    assign bus.LOG_OVF     = log_ovf;
endmodule
